// File: rtl/blit_sequencer.sv
// Blit command sequencer: decodes 96-bit commands, holds drawing state and walks clipped rect/image/line pixels.
// Define BLIT_SEQ_LINE_EN to build the Bresenham LINE engine; otherwise opcode 06 is consumed as a NOP.
module blit_sequencer #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 26,
    parameter int COLOR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [95:0]        cmd,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_dest_x,
    output logic [COORD_W-1:0] px_dest_y,
    output logic [COORD_W-1:0] px_src_x,
    output logic [COORD_W-1:0] px_src_y,
    output logic [1:0]         px_op,
    output logic [ADDR_W-1:0]  dest_addr,
    output logic [ADDR_W-1:0]  src_addr,
    output logic [15:0]        dest_bpl,
    output logic [15:0]        src_bpl,
    output logic [COLOR_W-1:0] fg_color,
    output logic [COLOR_W-1:0] bg_color,
    output logic               idle
);

    typedef logic signed [COORD_W-1:0] coord_t;

`ifdef BLIT_SEQ_LINE_EN
    typedef logic signed [COORD_W:0]   wide_t;
    typedef logic signed [COORD_W+1:0] wide2_t;
    typedef enum logic [2:0] {ST_IDLE, ST_RECT, ST_IMAGE, ST_LINE_INIT, ST_LINE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RECT, ST_IMAGE} state_t;
`endif

    localparam logic [7:0] OP_SET_DEST   = 8'h01;
    localparam logic [7:0] OP_SET_CLIP   = 8'h02;
    localparam logic [7:0] OP_SET_OFFSET = 8'h03;
    localparam logic [7:0] OP_SET_COLOR  = 8'h04;
    localparam logic [7:0] OP_RECT       = 8'h05;
    localparam logic [7:0] OP_LINE       = 8'h06;
    localparam logic [7:0] OP_SET_SRC    = 8'h07;
    localparam logic [7:0] OP_SRC_OFFSET = 8'h08;
    localparam logic [7:0] OP_IMAGE      = 8'h09;

    localparam coord_t C_ONE = coord_t'(1);
    localparam coord_t C_MAX = coord_t'((1 << (COORD_W - 1)) - 1);

    state_t             state_reg;
    logic               px_valid_reg;
    logic [1:0]         op_reg;
    coord_t             cur_x_reg, cur_y_reg;
    coord_t             lo_x_reg, hi_x_reg, hi_y_reg;
    coord_t             src_x_reg, src_y_reg, src_lo_x_reg;

    logic [ADDR_W-1:0]  dest_addr_reg, src_addr_reg;
    logic [15:0]        dest_bpl_reg, src_bpl_reg;
    logic [COLOR_W-1:0] fg_reg, bg_reg;
    coord_t             off_x_reg, off_y_reg, soff_x_reg, soff_y_reg;
    coord_t             clip_x1_reg, clip_y1_reg, clip_x2_reg, clip_y2_reg;

    logic [7:0] opcode;
    coord_t     a1_x, a1_y, a2_x, a2_y;
    logic       unused_cmd;

    assign opcode     = cmd[7:0];
    assign a1_x       = cmd[32 +: COORD_W];
    assign a1_y       = cmd[48 +: COORD_W];
    assign a2_x       = cmd[64 +: COORD_W];
    assign a2_y       = cmd[80 +: COORD_W];
    assign unused_cmd = ^cmd;

    // Offset-adjusted box (wrapping) intersected with the clip window.
    coord_t box_x1, box_y1, box_x2, box_y2;
    coord_t lo_x, lo_y, hi_x, hi_y;
    coord_t src_start_x, src_start_y;
    logic   box_empty;

    always_comb begin
        box_x1 = a1_x + off_x_reg;
        box_y1 = a1_y + off_y_reg;
        if (opcode == OP_IMAGE) begin
            box_x2 = box_x1 + a2_x;
            box_y2 = box_y1 + a2_y;
        end else begin
            box_x2 = a2_x + off_x_reg;
            box_y2 = a2_y + off_y_reg;
        end
        lo_x = (box_x1 > clip_x1_reg) ? box_x1 : clip_x1_reg;
        lo_y = (box_y1 > clip_y1_reg) ? box_y1 : clip_y1_reg;
        hi_x = (box_x2 < clip_x2_reg) ? box_x2 : clip_x2_reg;
        hi_y = (box_y2 < clip_y2_reg) ? box_y2 : clip_y2_reg;
        box_empty   = (lo_x >= hi_x) || (lo_y >= hi_y);
        src_start_x = soff_x_reg + (lo_x - box_x1);
        src_start_y = soff_y_reg + (lo_y - box_y1);
    end

    logic x_last, y_last;
    assign x_last = (cur_x_reg + C_ONE) == hi_x_reg;
    assign y_last = (cur_y_reg + C_ONE) == hi_y_reg;

`ifdef BLIT_SEQ_LINE_EN
    coord_t end_x_reg, end_y_reg;
    wide_t  dx_reg, dy_reg, err_reg;
    logic   sx_neg_reg, sy_neg_reg;

    wide_t  ln_ddx, ln_ddy, ln_dx, ln_dy, err_next;
    wide2_t e2, dx_e, dy_e, err_sum;
    logic   step_x, step_y, ln_at_end, cur_in, nxt_in;
    coord_t step_dx, step_dy, nxt_x, nxt_y;

    always_comb begin
        ln_ddx  = wide_t'(box_x2) - wide_t'(box_x1);
        ln_ddy  = wide_t'(box_y2) - wide_t'(box_y1);
        ln_dx   = ln_ddx[COORD_W] ? -ln_ddx : ln_ddx;
        ln_dy   = ln_ddy[COORD_W] ? -ln_ddy : ln_ddy;

        e2      = {err_reg, 1'b0};
        dx_e    = {dx_reg[COORD_W], dx_reg};
        dy_e    = {dy_reg[COORD_W], dy_reg};
        step_x  = e2 > -dy_e;
        step_y  = e2 < dx_e;
        err_sum = {err_reg[COORD_W], err_reg};
        if (step_x) err_sum = err_sum - dy_e;
        if (step_y) err_sum = err_sum + dx_e;
        err_next = err_sum[COORD_W:0];

        step_dx = '0;
        step_dy = '0;
        if (step_x) step_dx = sx_neg_reg ? -C_ONE : C_ONE;
        if (step_y) step_dy = sy_neg_reg ? -C_ONE : C_ONE;
        nxt_x = cur_x_reg + step_dx;
        nxt_y = cur_y_reg + step_dy;

        ln_at_end = (cur_x_reg == end_x_reg) && (cur_y_reg == end_y_reg);
        cur_in = (cur_x_reg >= clip_x1_reg) && (cur_x_reg < clip_x2_reg) &&
                 (cur_y_reg >= clip_y1_reg) && (cur_y_reg < clip_y2_reg);
        nxt_in = (nxt_x >= clip_x1_reg) && (nxt_x < clip_x2_reg) &&
                 (nxt_y >= clip_y1_reg) && (nxt_y < clip_y2_reg);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            px_valid_reg  <= 1'b0;
            op_reg        <= 2'd0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            lo_x_reg      <= '0;
            hi_x_reg      <= '0;
            hi_y_reg      <= '0;
            src_x_reg     <= '0;
            src_y_reg     <= '0;
            src_lo_x_reg  <= '0;
            dest_addr_reg <= '0;
            src_addr_reg  <= '0;
            dest_bpl_reg  <= '0;
            src_bpl_reg   <= '0;
            fg_reg        <= '0;
            bg_reg        <= '0;
            off_x_reg     <= '0;
            off_y_reg     <= '0;
            soff_x_reg    <= '0;
            soff_y_reg    <= '0;
            clip_x1_reg   <= '0;
            clip_y1_reg   <= '0;
            clip_x2_reg   <= C_MAX;
            clip_y2_reg   <= C_MAX;
`ifdef BLIT_SEQ_LINE_EN
            end_x_reg     <= '0;
            end_y_reg     <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            err_reg       <= '0;
            sx_neg_reg    <= 1'b0;
            sy_neg_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (opcode)
                            OP_SET_DEST: begin
                                dest_addr_reg <= cmd[32 +: ADDR_W];
                                dest_bpl_reg  <= cmd[64 +: 16];
                            end
                            OP_SET_SRC: begin
                                src_addr_reg <= cmd[32 +: ADDR_W];
                                src_bpl_reg  <= cmd[64 +: 16];
                            end
                            OP_SET_CLIP: begin
                                clip_x1_reg <= a1_x;
                                clip_y1_reg <= a1_y;
                                clip_x2_reg <= a2_x;
                                clip_y2_reg <= a2_y;
                            end
                            OP_SET_OFFSET: begin
                                off_x_reg <= a1_x;
                                off_y_reg <= a2_x;
                            end
                            OP_SRC_OFFSET: begin
                                soff_x_reg <= a1_x;
                                soff_y_reg <= a2_x;
                            end
                            OP_SET_COLOR: begin
                                fg_reg <= cmd[32 +: COLOR_W];
                                bg_reg <= cmd[64 +: COLOR_W];
                            end
                            OP_RECT, OP_IMAGE: begin
                                if (!box_empty) begin
                                    state_reg    <= (opcode == OP_IMAGE) ? ST_IMAGE : ST_RECT;
                                    px_valid_reg <= 1'b1;
                                    op_reg       <= (opcode == OP_IMAGE) ? 2'd1 : 2'd0;
                                    cur_x_reg    <= lo_x;
                                    cur_y_reg    <= lo_y;
                                    lo_x_reg     <= lo_x;
                                    hi_x_reg     <= hi_x;
                                    hi_y_reg     <= hi_y;
                                    if (opcode == OP_IMAGE) begin
                                        src_x_reg    <= src_start_x;
                                        src_y_reg    <= src_start_y;
                                        src_lo_x_reg <= src_start_x;
                                    end else begin
                                        src_x_reg    <= '0;
                                        src_y_reg    <= '0;
                                        src_lo_x_reg <= '0;
                                    end
                                end
                            end
`ifdef BLIT_SEQ_LINE_EN
                            OP_LINE: begin
                                state_reg  <= ST_LINE_INIT;
                                op_reg     <= 2'd0;
                                cur_x_reg  <= box_x1;
                                cur_y_reg  <= box_y1;
                                end_x_reg  <= box_x2;
                                end_y_reg  <= box_y2;
                                src_x_reg  <= '0;
                                src_y_reg  <= '0;
                                dx_reg     <= ln_dx;
                                dy_reg     <= ln_dy;
                                sx_neg_reg <= ln_ddx[COORD_W];
                                sy_neg_reg <= ln_ddy[COORD_W];
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                // px_valid is always high in these states, so px_ready alone is the handshake.
                ST_RECT, ST_IMAGE: begin
                    if (px_ready) begin
                        if (!x_last) begin
                            cur_x_reg <= cur_x_reg + C_ONE;
                            if (state_reg == ST_IMAGE) src_x_reg <= src_x_reg + C_ONE;
                        end else if (!y_last) begin
                            cur_x_reg <= lo_x_reg;
                            cur_y_reg <= cur_y_reg + C_ONE;
                            if (state_reg == ST_IMAGE) begin
                                src_x_reg <= src_lo_x_reg;
                                src_y_reg <= src_y_reg + C_ONE;
                            end
                        end else begin
                            state_reg    <= ST_IDLE;
                            px_valid_reg <= 1'b0;
                        end
                    end
                end
`ifdef BLIT_SEQ_LINE_EN
                ST_LINE_INIT: begin
                    err_reg      <= dx_reg - dy_reg;
                    px_valid_reg <= cur_in;
                    state_reg    <= ST_LINE;
                end
                // Clipped points carry px_valid=0 and advance without waiting for px_ready.
                ST_LINE: begin
                    if (!px_valid_reg || px_ready) begin
                        if (ln_at_end) begin
                            state_reg    <= ST_IDLE;
                            px_valid_reg <= 1'b0;
                        end else begin
                            cur_x_reg    <= nxt_x;
                            cur_y_reg    <= nxt_y;
                            err_reg      <= err_next;
                            px_valid_reg <= nxt_in;
                        end
                    end
                end
`endif
                default: begin
                    state_reg    <= ST_IDLE;
                    px_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE) && !reset;
    assign idle      = (state_reg == ST_IDLE) && !px_valid_reg && !cmd_valid;
    assign px_valid  = px_valid_reg;
    assign px_dest_x = cur_x_reg;
    assign px_dest_y = cur_y_reg;
    assign px_src_x  = src_x_reg;
    assign px_src_y  = src_y_reg;
    assign px_op     = op_reg;
    assign dest_addr = dest_addr_reg;
    assign src_addr  = src_addr_reg;
    assign dest_bpl  = dest_bpl_reg;
    assign src_bpl   = src_bpl_reg;
    assign fg_color  = fg_reg;
    assign bg_color  = bg_reg;

endmodule

// File: tb/tb_blit_sequencer.sv
// Directed bench for blit_sequencer: expected pixels are queued when a draw is issued and popped on each accepted beat.
module tb_blit_sequencer;

    localparam int CW = 16;
    localparam int AW = 26;
    localparam int KW = 8;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_DEST   = 8'h01;
    localparam logic [7:0] OP_SET_CLIP   = 8'h02;
    localparam logic [7:0] OP_SET_OFFSET = 8'h03;
    localparam logic [7:0] OP_SET_COLOR  = 8'h04;
    localparam logic [7:0] OP_RECT       = 8'h05;
    localparam logic [7:0] OP_LINE       = 8'h06;
    localparam logic [7:0] OP_SET_SRC    = 8'h07;
    localparam logic [7:0] OP_SRC_OFFSET = 8'h08;
    localparam logic [7:0] OP_IMAGE      = 8'h09;

    logic          clock = 1'b0;
    logic          reset;
    logic [95:0]   cmd;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          px_valid;
    logic          px_ready;
    logic [CW-1:0] px_dest_x, px_dest_y, px_src_x, px_src_y;
    logic [1:0]    px_op;
    logic [AW-1:0] dest_addr, src_addr;
    logic [15:0]   dest_bpl, src_bpl;
    logic [KW-1:0] fg_color, bg_color;
    logic          idle;

    blit_sequencer #(.COORD_W(CW), .ADDR_W(AW), .COLOR_W(KW)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .px_valid(px_valid), .px_ready(px_ready), .px_dest_x(px_dest_x), .px_dest_y(px_dest_y),
        .px_src_x(px_src_x), .px_src_y(px_src_y), .px_op(px_op), .dest_addr(dest_addr),
        .src_addr(src_addr), .dest_bpl(dest_bpl), .src_bpl(src_bpl), .fg_color(fg_color),
        .bg_color(bg_color), .idle(idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] dx;
        logic [15:0] dy;
        logic [15:0] sx;
        logic [15:0] sy;
        logic [1:0]  op;
    } px_t;

    px_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  ready_mode = 0;   // 0: always ready, 1: toggle every cycle, 2: never ready

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xy(input int x, input int y);
        return {16'(y), 16'(x)};
    endfunction

    task automatic expect_px(input int dx, input int dy, input int sx, input int sy, input int op);
        px_t p;
        p.dx = 16'(dx);
        p.dy = 16'(dy);
        p.sx = 16'(sx);
        p.sy = 16'(sy);
        p.op = 2'(op);
        sb.push_back(p);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the command.
    task automatic send(input logic [7:0] op, input logic [31:0] a1, input logic [31:0] a2);
        int n;
        n = 0;
        cmd       = {a2, a1, 24'h0, op};
        cmd_valid = 1'b1;
        @(negedge clock);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("send_ready", 32'(cmd_ready), 1);
        $display("cmd op=%02h arg1=%08h arg2=%08h", op, a1, a2);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cycles_to_ready(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cmd_ready && n < 100);
    endtask

    task automatic cycles_to_valid(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!px_valid && n < 100);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(sb.size() == 0 && idle) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_left"}, 32'(sb.size()), 0);
        chk({tag, "_idle"}, 32'(idle), 1);
        @(posedge clock);
        #1;
    endtask

    // px_ready driver
    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       px_ready = 1'b1;
                1:       px_ready = ~px_ready;
                default: px_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard pops on accepted beats, hold checks while stalled.
    logic        stall_prev = 1'b0;
    logic [15:0] h_dx, h_dy, h_sx, h_sy;
    logic [1:0]  h_op;
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(px_valid), 1);
                chk("hold_dx", 32'(px_dest_x), 32'(h_dx));
                chk("hold_dy", 32'(px_dest_y), 32'(h_dy));
                chk("hold_sx", 32'(px_src_x), 32'(h_sx));
                chk("hold_sy", 32'(px_src_y), 32'(h_sy));
                chk("hold_op", 32'(px_op), 32'(h_op));
            end
            if (px_valid && px_ready) begin
                $display("px dest=(%0d,%0d) src=(%0d,%0d) op=%0d", $signed(px_dest_x), $signed(px_dest_y),
                         $signed(px_src_x), $signed(px_src_y), px_op);
                if (sb.size() == 0) begin
                    chk("unexpected_px", 32'(px_valid), 0);
                end else begin
                    px_t e;
                    e = sb.pop_front();
                    chk("px_dx", 32'(px_dest_x), 32'(e.dx));
                    chk("px_dy", 32'(px_dest_y), 32'(e.dy));
                    chk("px_sx", 32'(px_src_x), 32'(e.sx));
                    chk("px_sy", 32'(px_src_y), 32'(e.sy));
                    chk("px_op", 32'(px_op), 32'(e.op));
                end
            end
            stall_prev = px_valid && !px_ready;
            h_dx = px_dest_x;
            h_dy = px_dest_y;
            h_sx = px_src_x;
            h_sy = px_src_y;
            h_op = px_op;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        cmd       = '0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_px_valid", 32'(px_valid), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_idle", 32'(idle), 1);
        chk("post_rst_fg", 32'(fg_color), 0);
        chk("post_rst_bg", 32'(bg_color), 0);
        chk("post_rst_daddr", 32'(dest_addr), 0);
        chk("post_rst_dbpl", 32'(dest_bpl), 0);
        chk("post_rst_saddr", 32'(src_addr), 0);
        @(posedge clock);
        #1;

        // Reset clip window starts at (0,0)
        expect_px(0, 0, 0, 0, 0);
        expect_px(1, 0, 0, 0, 0);
        send(OP_RECT, xy(-1, -1), xy(2, 1));
        drain("rst_clip");

        send(OP_SET_DEST, 32'h0123_4567, 32'd320);
        chk("dest_addr", 32'(dest_addr), 32'h0123_4567);
        chk("dest_bpl", 32'(dest_bpl), 320);
        send(OP_SET_COLOR, 32'h5A, 32'hA5);
        chk("fg_color", 32'(fg_color), 32'h5A);
        chk("bg_color", 32'(bg_color), 32'hA5);

        // Offset rectangle; IDLE and ready the cycle after the last accept
        send(OP_SET_CLIP, xy(0, 0), xy(320, 240));
        send(OP_SET_OFFSET, 32'd10, 32'd5);
        expect_px(10, 5, 0, 0, 0);
        expect_px(11, 5, 0, 0, 0);
        expect_px(12, 5, 0, 0, 0);
        expect_px(10, 6, 0, 0, 0);
        expect_px(11, 6, 0, 0, 0);
        expect_px(12, 6, 0, 0, 0);
        send(OP_RECT, xy(0, 0), xy(3, 2));
        cycles_to_ready(n);
        chk("rect6_ready_cycle", 32'(n), 7);
        drain("rect6");

        // Negative corner clipped to the window
        send(OP_SET_OFFSET, 32'd0, 32'd0);
        expect_px(0, 0, 0, 0, 0);
        expect_px(1, 0, 0, 0, 0);
        send(OP_RECT, xy(-2, -1), xy(2, 1));
        drain("rect_neg");

        // Zero-width rectangle: nothing emitted, next command next cycle
        send(OP_RECT, xy(5, 5), xy(5, 9));
        cycles_to_ready(n);
        chk("empty_ready_cycle", 32'(n), 1);
        chk("empty_no_px", 32'(px_valid), 0);
        drain("rect_empty");

        // Unknown opcode and NOP are consumed in one cycle
        send(8'hAB, 32'h1234, 32'h5678);
        cycles_to_ready(n);
        chk("unknown_ready_cycle", 32'(n), 1);
        send(OP_NOP, 32'h0, 32'h0);
        drain("nop");

        // Image with left edge clipped
        send(OP_SET_SRC, 32'h1000, 32'd64);
        chk("src_addr", 32'(src_addr), 32'h1000);
        chk("src_bpl", 32'(src_bpl), 64);
        send(OP_SRC_OFFSET, 32'd4, 32'd8);
        send(OP_SET_CLIP, xy(2, 0), xy(320, 240));
        expect_px(2, 0, 6, 8, 1);
        expect_px(3, 0, 7, 8, 1);
        send(OP_IMAGE, xy(0, 0), xy(4, 1));
        drain("image_clip");

        // Two-row image exercises source row wrap
        expect_px(3, 1, 4, 8, 1);
        expect_px(4, 1, 5, 8, 1);
        expect_px(3, 2, 4, 9, 1);
        expect_px(4, 2, 5, 9, 1);
        send(OP_IMAGE, xy(3, 1), xy(2, 2));
        drain("image_2x2");
        send(OP_SET_CLIP, xy(0, 0), xy(320, 240));

`ifdef BLIT_SEQ_LINE_EN
        ready_mode = 1;
        repeat (2) @(posedge clock);
        #1;
        expect_px(0, 0, 0, 0, 0);
        expect_px(1, 0, 0, 0, 0);
        expect_px(2, 1, 0, 0, 0);
        expect_px(3, 1, 0, 0, 0);
        send(OP_LINE, xy(0, 0), xy(3, 1));
        drain("line_toggle");
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;

        expect_px(0, 0, 0, 0, 0);
        expect_px(1, 0, 0, 0, 0);
        send(OP_LINE, xy(-2, 0), xy(1, 0));
        cycles_to_valid(n);
        chk("line_clip_first_valid", 32'(n), 4);
        drain("line_clip");

        expect_px(3, 3, 0, 0, 0);
        expect_px(2, 2, 0, 0, 0);
        expect_px(2, 1, 0, 0, 0);
        expect_px(1, 0, 0, 0, 0);
        send(OP_LINE, xy(3, 3), xy(1, 0));
        drain("line_steep_neg");

        expect_px(5, 5, 0, 0, 0);
        send(OP_LINE, xy(5, 5), xy(5, 5));
        drain("line_point");
`else
        send(OP_LINE, xy(0, 0), xy(3, 1));
        cycles_to_ready(n);
        chk("line_nop_ready_cycle", 32'(n), 1);
        chk("line_nop_no_px", 32'(px_valid), 0);
        drain("line_nop");
`endif

        // Reset while stalled mid-rectangle
        ready_mode = 2;
        repeat (2) @(posedge clock);
        #1;
        send(OP_RECT, xy(0, 0), xy(4, 4));
        @(negedge clock);
        chk("stall_valid", 32'(px_valid), 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("midrst_px_valid", 32'(px_valid), 0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clock);
        #1;
        reset      = 1'b0;
        ready_mode = 0;
        @(negedge clock);
        chk("midrst_idle", 32'(idle), 1);
        chk("midrst_px_after", 32'(px_valid), 0);
        chk("midrst_fg", 32'(fg_color), 0);
        @(posedge clock);
        #1;
        expect_px(0, 0, 0, 0, 0);
        send(OP_RECT, xy(-1, 0), xy(1, 1));
        drain("midrst_clip");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
